// File: rtl/mem_resp_pkg.sv
// Shared types for the memory response shaper: response modes, FSM states
// and the captured core request.
package mem_resp_pkg;

  localparam logic [1:0] MODE_ZERO  = 2'd0;
  localparam logic [1:0] MODE_FIXED = 2'd1;
  localparam logic [1:0] MODE_RAND  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

endpackage

// File: rtl/mem_req_checker.sv
// Sticky protocol checker: the core must hold its request, unchanged,
// from acceptance until the response cycle has completed.
module mem_req_checker
  import mem_resp_pkg::*;
(
  input  logic     clk,
  input  logic     resetn,
  input  logic     active,
  input  logic     req_valid,
  input  mem_req_t req,
  input  mem_req_t cap,
  output logic     proto_err
);

  logic proto_err_d, proto_err_q;

  always_comb begin
    proto_err_d = proto_err_q;
    if (active && (!req_valid || (req != cap))) proto_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) proto_err_q <= 1'b0;
    else         proto_err_q <= proto_err_d;
  end

  assign proto_err = proto_err_q;

endmodule

// File: rtl/mem_resp_shaper.sv
// Memory responder for a valid/ready core bus with zero, fixed or bounded
// random wait states; counts transactions and tracks the worst wait seen.
module mem_resp_shaper
  import mem_resp_pkg::*;
#(
  parameter int unsigned MODE      = 2,
  parameter int unsigned MAX_WAIT  = 3,
  parameter int unsigned FIXED_LAT = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             mem_valid,
  input  logic             mem_instr,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic             mem_ready,
  output logic [31:0]      mem_rdata,
  input  logic             rand_ready,
  input  logic [31:0]      rand_rdata,
  output logic             proto_err,
  output logic [CNT_W-1:0] txn_cnt,
  output logic [7:0]       max_wait
);

  // Mode 3 (and anything unknown) collapses to zero-wait.
  localparam logic [1:0] MODE_EFF = (MODE == 1) ? MODE_FIXED :
                                    (MODE == 2) ? MODE_RAND  : MODE_ZERO;
  localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);
  localparam logic [7:0] FIX_W8 = 8'(FIXED_LAT);

  state_e           state_d, state_q;
  logic [7:0]       wait_cnt_d, wait_cnt_q;
  mem_req_t         cap_d, cap_q;
  logic             ready_d, ready_q;
  logic [31:0]      rdata_d, rdata_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [7:0]       mw_d, mw_q;
  logic             grant;
  mem_req_t         req;

  assign req = '{instr: mem_instr, addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb};

  always_comb begin
    grant = 1'b1;
    case (MODE_EFF)
      MODE_FIXED: grant = (wait_cnt_q == FIX_W8);
      MODE_RAND:  grant = rand_ready || (wait_cnt_q == MAX_W8);
      default:    grant = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    cap_d      = cap_q;
    ready_d    = ready_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    mw_d       = mw_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          state_d    = ST_WAIT;
          wait_cnt_d = 8'd0;
          cap_d      = req;
        end
      end
      ST_WAIT: begin
        if (grant) begin
          state_d = ST_RESP;
          ready_d = 1'b1;
          rdata_d = rand_rdata;
          cnt_d   = cnt_q + CNT_W'(1);
          mw_d    = (wait_cnt_q > mw_q) ? wait_cnt_q : mw_q;
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        ready_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 8'd0;
      cap_q      <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= 32'd0;
      cnt_q      <= '0;
      mw_q       <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      cap_q      <= cap_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      mw_q       <= mw_d;
    end
  end

  mem_req_checker u_chk (
    .clk       (clk),
    .resetn    (resetn),
    .active    (state_q != ST_IDLE),
    .req_valid (mem_valid),
    .req       (req),
    .cap       (cap_q),
    .proto_err (proto_err)
  );

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign txn_cnt   = cnt_q;
  assign max_wait  = mw_q;

endmodule

// File: tb/tb_mem_resp_shaper.sv
// Bench for mem_resp_shaper: five differently-configured instances share
// clock, reset and random stimulus; each has its own request bus.
module tb_mem_resp_shaper;

  localparam int NDUT = 5;
  // 0: ZERO, 1: FIXED 3, 2: RAND 3, 3: ZERO with 2-bit counter, 4: RAND 0
  localparam int P_MODE [NDUT] = '{0, 1, 2, 0, 2};
  localparam int P_MW   [NDUT] = '{3, 3, 3, 3, 0};
  localparam int P_FL   [NDUT] = '{1, 3, 1, 1, 1};
  localparam int P_CW   [NDUT] = '{16, 16, 16, 2, 16};

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic [15:0] cnt;
  } exp_t;

  logic clk, resetn;
  logic [NDUT-1:0] valid, instr, rdy, perr;
  logic [31:0] addr [NDUT];
  logic [31:0] wdata[NDUT];
  logic [3:0]  wstrb[NDUT];
  logic [31:0] rdata[NDUT];
  logic [15:0] cnt  [NDUT];
  logic [7:0]  mw   [NDUT];
  logic        rand_ready;
  logic [31:0] rand_rdata;

  exp_t sb[$];
  int n_run, n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic [P_CW[g]-1:0] c;
    mem_resp_shaper #(
      .MODE(P_MODE[g]), .MAX_WAIT(P_MW[g]), .FIXED_LAT(P_FL[g]), .CNT_W(P_CW[g])
    ) u_dut (
      .clk(clk), .resetn(resetn),
      .mem_valid(valid[g]), .mem_instr(instr[g]), .mem_addr(addr[g]),
      .mem_wdata(wdata[g]), .mem_wstrb(wstrb[g]),
      .mem_ready(rdy[g]), .mem_rdata(rdata[g]),
      .rand_ready(rand_ready), .rand_rdata(rand_rdata),
      .proto_err(perr[g]), .txn_cnt(c), .max_wait(mw[g])
    );
    assign cnt[g] = 16'(c);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge with DUT d idle; leaves it idle one
  // cycle after the response, so consecutive calls are back-to-back.
  // rand_ready rises at WAIT cycle g; k is the expected wait count.
  task automatic txn(input int d, input logic ins, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, input logic [31:0] rd, input int g, input int k,
                     input logic [15:0] ecnt);
    exp_t e;
    int   lat;
    bit   seen;
    valid[d] = 1'b1; instr[d] = ins; addr[d] = a; wdata[d] = wd; wstrb[d] = ws;
    rand_rdata = rd;
    e.lat = 2 + k; e.rdata = rd; e.cnt = ecnt;
    sb.push_back(e);
    lat = 0; seen = 0;
    while (!seen && lat < 300) begin
      rand_ready = (lat >= g + 1);
      @(posedge clk); lat++; #1;
      if (rdy[d]) seen = 1;
    end
    rand_ready = 1'b0;
    e = sb.pop_front();
    if (!seen) chk("ready_timeout", 32'd0, 32'd1);
    else begin
      chk("latency", 32'(lat), 32'(e.lat));
      chk("rdata", rdata[d], e.rdata);
      chk("txn_cnt", 32'(cnt[d]), 32'(e.cnt));
    end
    @(posedge clk); #1;
    chk("ready_one_cycle", 32'(rdy[d]), 32'd0);
    chk("rdata_hold", rdata[d], rd);
    valid[d] = 1'b0;
  endtask

  task automatic reset_check();
    resetn = 1'b0;
    valid  = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk("rst_ready", 32'(rdy[i]), 32'd0);
      chk("rst_cnt", 32'(cnt[i]), 32'd0);
      chk("rst_perr", 32'(perr[i]), 32'd0);
    end
    chk("rst_rdata", rdata[0], 32'd0);
    chk("rst_maxwait", 32'(mw[2]), 32'd0);
  endtask

  initial begin : main
    int   k, g, mwm, bound;
    logic [15:0] c2;
    logic [31:0] r;
    n_run = 0; n_fail = 0;
    resetn = 1'b0; valid = '0; instr = '0; rand_ready = 1'b0; rand_rdata = 32'd0;
    for (int i = 0; i < NDUT; i++) begin
      addr[i] = 32'd0; wdata[i] = 32'd0; wstrb[i] = 4'd0;
    end
    reset_check();
    resetn = 1'b1;

    // zero-wait, accepted right out of reset
    txn(0, 1'b1, 32'h100, 32'd0, 4'h0, 32'h1234_5678, 0, 0, 16'd1);
    chk("zero_maxwait", 32'(mw[0]), 32'd0);

    // fixed latency 3, rand_ready high throughout must be ignored
    txn(1, 1'b0, 32'h40, 32'd0, 4'h0, 32'hDEAD_BEEF, 0, 3, 16'd1);
    chk("fixed_maxwait", 32'(mw[1]), 32'd3);

    // bounded random: never ready, then ready at first WAIT
    txn(2, 1'b0, 32'h80, 32'd0, 4'h0, 32'hCAFE_0001, 255, 3, 16'd1);
    chk("rand_maxwait_cap", 32'(mw[2]), 32'd3);
    txn(2, 1'b0, 32'h84, 32'd0, 4'h0, 32'hCAFE_0002, 0, 0, 16'd2);
    chk("rand_maxwait_keep", 32'(mw[2]), 32'd3);

    // random with bound 0 is zero-wait
    txn(4, 1'b0, 32'h90, 32'd0, 4'h0, 32'h0BAD_F00D, 255, 0, 16'd1);
    chk("rand0_maxwait", 32'(mw[4]), 32'd0);

    // 2-bit counter wrap over five back-to-back transactions (mixed writes)
    c2 = 16'd0;
    for (int i = 0; i < 5; i++) begin
      c2 = (c2 + 16'd1) & 16'd3;
      txn(3, 1'b0, 32'h1000 + 32'(4 * i), 32'hA5A5_0000 + 32'(i), (i % 2) ? 4'hF : 4'h0,
          32'h5000 + 32'(i), 0, 0, c2);
    end

    // random ready timing on the bounded-random instance
    mwm = 3;
    for (int i = 0; i < 6; i++) begin
      g = int'($urandom_range(0, 5));
      k = (g < 3) ? g : 3;
      if (k > mwm) mwm = k;
      r = $urandom;
      txn(2, 1'b1, 32'h2000 + 32'(4 * i), 32'd0, 4'h0, r, g, k, 16'(3 + i));
    end
    chk("rand_maxwait_final", 32'(mw[2]), 32'(mwm));

    for (int i = 0; i < NDUT; i++) chk("clean_perr", 32'(perr[i]), 32'd0);

    // request address changes mid-WAIT -> sticky protocol error
    valid[1] = 1'b1; instr[1] = 1'b0; addr[1] = 32'h200; wdata[1] = 32'd0; wstrb[1] = 4'h0;
    @(posedge clk); #1;
    chk("perr_before", 32'(perr[1]), 32'd0);
    addr[1] = 32'h204;
    @(posedge clk); #1;
    chk("perr_set", 32'(perr[1]), 32'd1);
    bound = 0;
    while (!rdy[1] && bound < 50) begin @(posedge clk); #1; bound++; end
    chk("perr_resp_seen", 32'(rdy[1]), 32'd1);
    @(posedge clk); #1;
    valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("perr_sticky", 32'(perr[1]), 32'd1);
    chk("perr_other", 32'(perr[0]), 32'd0);

    reset_check();
    resetn = 1'b1;

    // reset pulse mid-WAIT abandons the transaction
    valid[1] = 1'b1; addr[1] = 32'h300;
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("rstwait_ready", 32'(rdy[1]), 32'd0);
    chk("rstwait_cnt", 32'(cnt[1]), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    txn(1, 1'b0, 32'h300, 32'd0, 4'h0, 32'h7777_0001, 0, 3, 16'd1);
    chk("rstwait_perr", 32'(perr[1]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_resp_shaper.md
MEM_RESP_SHAPER -- requirements
Module: mem_resp_shaper

Interface
REQ-001 SHALL have parameter MODE, default 2, response mode: 0 ZERO-wait, 1 FIXED latency, 2 RAND bounded; value 3 behaves as 0.
REQ-002 SHALL have parameter MAX_WAIT, default 3, maximum WAIT cycles in RAND mode (0..255).
REQ-003 SHALL have parameter FIXED_LAT, default 1, WAIT cycles in FIXED mode (0..255).
REQ-004 SHALL have parameter CNT_W, default 16, width of the transaction counter.
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port resetn  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports mem_valid in 1, mem_instr in 1, mem_addr in 32, mem_wdata in 32, mem_wstrb in 4: core request, held until consumed.
REQ-008 SHALL have ports mem_ready out 1 and mem_rdata out 32: registered response to core.
REQ-009 SHALL have ports rand_ready in 1 and rand_rdata in 32: unconstrained stimulus (solver-free or bench-driven).
REQ-010 SHALL have ports proto_err out 1 (sticky), txn_cnt out CNT_W, max_wait out 8.

Function
REQ-011 SHALL implement states IDLE, WAIT, RESP; all outputs registered.
REQ-012 IDLE: on edge with mem_valid=1 -> WAIT, wait_cnt<=0, capture instr/addr/wdata/wstrb; else stay.
REQ-013 WAIT: grant = ZERO: 1; FIXED: wait_cnt==FIXED_LAT; RAND: rand_ready or wait_cnt==MAX_WAIT.
REQ-014 WAIT with grant: mem_ready<=1, mem_rdata<=rand_rdata, txn_cnt<=txn_cnt+1 (wraps mod 2^CNT_W), -> RESP.
REQ-015 WAIT without grant: wait_cnt<=wait_cnt+1, stay.
REQ-016 RESP: mem_ready<=0, -> IDLE; mem_ready high exactly one cycle per transaction.
REQ-017 Latency: valid first sampled at edge 0 -> mem_ready visible after edge 2+k, k = WAIT cycles without grant; k=0 ZERO, k=FIXED_LAT FIXED, k<=MAX_WAIT RAND.
REQ-018 mem_rdata SHALL hold last granted value outside RESP; value for writes is don't-care to core but still driven.
REQ-019 max_wait SHALL update on grant to max(max_wait, wait_cnt), saturating at 255.
REQ-020 proto_err SHALL set in WAIT or RESP when mem_valid=0 or any request field differs from captured value; cleared only by reset.
REQ-021 Back-to-back: mem_valid high in the IDLE cycle after RESP starts a new transaction normally.
REQ-022 rand_ready SHALL be ignored outside WAIT and in ZERO/FIXED modes.
REQ-023 RAND with MAX_WAIT=0 SHALL behave identically to ZERO.

Reset
REQ-024 resetn low SHALL immediately force state IDLE, mem_ready=0, mem_rdata=0, proto_err=0, txn_cnt=0, max_wait=0, wait_cnt=0, regardless of current state.
REQ-025 Reset during WAIT/RESP SHALL abandon the transaction without incrementing txn_cnt.
REQ-026 First transaction SHALL be accepted in first cycle after resetn deasserts with mem_valid=1.

Structure
REQ-027 Package mem_resp_pkg SHALL hold mode constants (MODE_ZERO/FIXED/RAND) and state enum.
REQ-028 Request-stability check (REQ-020) SHALL be sub-module mem_req_checker; remainder in mem_resp_shaper.
REQ-029 Block SHALL be synthesizable and formal-friendly (no initial values relied on beyond reset).

Verification
REQ-030 MODE=0, valid at cycle 0, addr 0x100 held -> mem_ready high cycle 2 only, txn_cnt=1, max_wait=0.
REQ-031 MODE=1, FIXED_LAT=3, read addr 0x40, rand_rdata=0xDEADBEEF at grant -> mem_ready cycle 5, mem_rdata=0xDEADBEEF.
REQ-032 MODE=2, MAX_WAIT=3, rand_ready=0 always -> mem_ready cycle 5, max_wait=3; rand_ready=1 at first WAIT -> cycle 2.
REQ-033 mem_addr changes 0x200->0x204 during WAIT -> proto_err=1 next cycle, stays 1 until resetn low.
REQ-034 resetn pulsed low during WAIT -> mem_ready=0 immediately, txn_cnt unchanged from pre-transaction value 0, IDLE after release.
REQ-035 CNT_W=2, five back-to-back transactions in MODE=0 -> txn_cnt sequence 1,2,3,0,1, each mem_ready one cycle.
